// File: rtl/pll_dyn_ctrl_if.sv
// ---------------------------------------------------------------------------
// pll_dyn_ctrl_if
//
// Host-side bundle of the PLL dynamic-delay controller: the delay update
// req/ack handshake plus the status/clear signals the host observes.
//
// Signals:
//   DELAY_REQ   host -> ctrl  request to load DELAY_VAL; held until DELAY_ACK
//   DELAY_VAL   host -> ctrl  requested feedback delay, stable while DELAY_REQ
//   CLR_STATUS  host -> ctrl  clears the sticky LOCK_LOST flag
//   DELAY_ACK   ctrl -> host  one-cycle pulse, coincident with the delay update
//   READY       ctrl -> host  PLL locked and qualified
//   LOCK_LOST   ctrl -> host  sticky: lock dropped while running
//   RETRY_CNT   ctrl -> host  failed lock attempts since reset (saturating)
//   FAIL        ctrl -> host  retry budget exhausted; terminal until reset
//
// Modports: master = host side, slave = controller side.
// ---------------------------------------------------------------------------
interface pll_dyn_ctrl_if;
    logic       DELAY_REQ;
    logic [7:0] DELAY_VAL;
    logic       CLR_STATUS;
    logic       DELAY_ACK;
    logic       READY;
    logic       LOCK_LOST;
    logic [7:0] RETRY_CNT;
    logic       FAIL;

    modport master (
        output DELAY_REQ,
        output DELAY_VAL,
        output CLR_STATUS,
        input  DELAY_ACK,
        input  READY,
        input  LOCK_LOST,
        input  RETRY_CNT,
        input  FAIL
    );

    modport slave (
        input  DELAY_REQ,
        input  DELAY_VAL,
        input  CLR_STATUS,
        output DELAY_ACK,
        output READY,
        output LOCK_LOST,
        output RETRY_CNT,
        output FAIL
    );
endinterface

// File: rtl/pll_dyn_ctrl.sv
// ---------------------------------------------------------------------------
// pll_dyn_ctrl
//
// Control-side companion for an iCE40 SB_PLL40_CORE running with dynamic
// feedback delay. Runs on the PLL reference clock so it works before lock.
// Sequences the PLL active-low reset, waits for LOCK with a timeout,
// qualifies lock over a stability window, retries on failure up to a limit,
// and applies host delay updates with a req/ack handshake followed by a
// fresh lock qualification.
//
// Ports:
//   REFERENCECLK      in   controller clock (PLL reference clock)
//   RESET             in   synchronous, active-high reset
//   PLL_LOCK          in   raw LOCK from the PLL (asynchronous)
//   PLL_RESETB        out  PLL RESET pin, active-low
//   PLL_DYNAMICDELAY  out  PLL DYNAMICDELAY bus
//   host              slave modport of pll_dyn_ctrl_if (handshake + status)
// ---------------------------------------------------------------------------
module pll_dyn_ctrl #(
    parameter int         RST_CYCLES    = 16,
    parameter int         LOCK_TIMEOUT  = 4096,
    parameter int         STABLE_CYCLES = 64,
    parameter int         MAX_RETRIES   = 8,
    parameter logic [7:0] DELAY_INIT    = 8'h00
) (
    input  logic          REFERENCECLK,
    input  logic          RESET,
    input  logic          PLL_LOCK,
    output logic          PLL_RESETB,
    output logic [7:0]    PLL_DYNAMICDELAY,
    pll_dyn_ctrl_if.slave host
);

    // One shared counter covers the reset hold, the lock timeout and the
    // stability window; it is sized for the longest of the three.
    localparam int CNT_MAX_A = (RST_CYCLES > STABLE_CYCLES) ? RST_CYCLES : STABLE_CYCLES;
    localparam int CNT_MAX   = (CNT_MAX_A > LOCK_TIMEOUT) ? CNT_MAX_A : LOCK_TIMEOUT;
    localparam int CNT_W     = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] CNT_ZERO    = '0;
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [7:0]       RETRY_LIMIT = 8'(MAX_RETRIES);

    typedef enum logic [2:0] {
        S_RST,
        S_WAIT,
        S_SETTLE,
        S_RUN,
        S_FAIL
    } state_e;

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             lock_meta_q;
    logic             lock_s_q;
    logic             resetb_q;
    logic [7:0]       delay_q;
    logic             ack_q;
    logic             ready_q;
    logic             lost_q;
    logic [7:0]       retry_q;
    logic             fail_q;

    // Saturating increment of the retry counter, used on a lock timeout.
    logic [7:0]       retry_d;

    assign retry_d = (retry_q == 8'hFF) ? retry_q : (retry_q + 8'd1);

    assign PLL_RESETB       = resetb_q;
    assign PLL_DYNAMICDELAY = delay_q;
    assign host.DELAY_ACK   = ack_q;
    assign host.READY       = ready_q;
    assign host.LOCK_LOST   = lost_q;
    assign host.RETRY_CNT   = retry_q;
    assign host.FAIL        = fail_q;

    always_ff @(posedge REFERENCECLK) begin
        if (RESET) begin
            state_q     <= S_RST;
            cnt_q       <= CNT_ZERO;
            lock_meta_q <= 1'b0;
            lock_s_q    <= 1'b0;
            resetb_q    <= 1'b0;
            delay_q     <= DELAY_INIT;
            ack_q       <= 1'b0;
            ready_q     <= 1'b0;
            lost_q      <= 1'b0;
            retry_q     <= 8'd0;
            fail_q      <= 1'b0;
        end else begin
            // PLL_LOCK is asynchronous to the reference clock.
            lock_meta_q <= PLL_LOCK;
            lock_s_q    <= lock_meta_q;

            ack_q <= 1'b0;

            // A lock-loss set later in this block overrides the clear.
            if (host.CLR_STATUS) begin
                lost_q <= 1'b0;
            end

            case (state_q)
                S_RST: begin
                    resetb_q <= 1'b0;
                    ready_q  <= 1'b0;
                    if (cnt_q == RST_LAST) begin
                        state_q  <= S_WAIT;
                        cnt_q    <= CNT_ZERO;
                        resetb_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end

                S_WAIT: begin
                    // Lock takes priority over a coincident timeout.
                    if (lock_s_q) begin
                        state_q <= S_SETTLE;
                        cnt_q   <= CNT_ZERO;
                    end else if (cnt_q == WAIT_LAST) begin
                        retry_q  <= retry_d;
                        cnt_q    <= CNT_ZERO;
                        resetb_q <= 1'b0;
                        if (retry_d >= RETRY_LIMIT) begin
                            state_q <= S_FAIL;
                            fail_q  <= 1'b1;
                        end else begin
                            state_q <= S_RST;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end

                S_SETTLE: begin
                    // A lock drop here restarts the timeout but is not a retry.
                    if (!lock_s_q) begin
                        state_q <= S_WAIT;
                        cnt_q   <= CNT_ZERO;
                    end else if (cnt_q == SETTLE_LAST) begin
                        state_q <= S_RUN;
                        cnt_q   <= CNT_ZERO;
                        ready_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end

                S_RUN: begin
                    // Lock loss beats a pending delay request; the request
                    // remains held by the host and is serviced after re-lock.
                    if (!lock_s_q) begin
                        state_q  <= S_RST;
                        cnt_q    <= CNT_ZERO;
                        resetb_q <= 1'b0;
                        ready_q  <= 1'b0;
                        lost_q   <= 1'b1;
                    end else if (host.DELAY_REQ) begin
                        state_q <= S_SETTLE;
                        cnt_q   <= CNT_ZERO;
                        delay_q <= host.DELAY_VAL;
                        ack_q   <= 1'b1;
                        ready_q <= 1'b0;
                    end
                end

                S_FAIL: begin
                    resetb_q <= 1'b0;
                    ready_q  <= 1'b0;
                    fail_q   <= 1'b1;
                end

                default: begin
                    state_q  <= S_RST;
                    cnt_q    <= CNT_ZERO;
                    resetb_q <= 1'b0;
                    ready_q  <= 1'b0;
                end
            endcase
        end
    end

    // The handshake never acknowledges on back-to-back cycles, and a failed
    // controller keeps the PLL in reset.
    a_ack_single: assert property (@(posedge REFERENCECLK) disable iff (RESET)
        ack_q |=> !ack_q);
    a_fail_holds_reset: assert property (@(posedge REFERENCECLK) disable iff (RESET)
        fail_q |-> !resetb_q);

endmodule

// File: tb/tb_pll_dyn_ctrl.sv
module tb_pll_dyn_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       lock = 1'b0;
    logic       resetb;
    logic [7:0] dly;

    pll_dyn_ctrl_if hif ();

    pll_dyn_ctrl #(
        .RST_CYCLES    (4),
        .LOCK_TIMEOUT  (32),
        .STABLE_CYCLES (8),
        .MAX_RETRIES   (3),
        .DELAY_INIT    (8'h05)
    ) dut (
        .REFERENCECLK     (clk),
        .RESET            (rst),
        .PLL_LOCK         (lock),
        .PLL_RESETB       (resetb),
        .PLL_DYNAMICDELAY (dly),
        .host             (hif.slave)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Observed vector: {RESETB, READY, ACK, LOST, FAIL, RETRY[7:0], DELAY[7:0]}
    typedef struct {
        string      name;
        logic       rst;
        logic       lock;
        logic       req;
        logic [7:0] val;
        logic       clr;
        int         n;
        logic [20:0] exp;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [20:0] obs();
        return {resetb, hif.READY, hif.DELAY_ACK, hif.LOCK_LOST, hif.FAIL, hif.RETRY_CNT, dly};
    endfunction

    task automatic add(input string name, input logic r, input logic lk, input logic rq,
                       input logic [7:0] v, input logic c, input int n,
                       input logic e_rb, input logic e_rdy, input logic e_ack, input logic e_lost,
                       input logic e_fail, input logic [7:0] e_retry, input logic [7:0] e_dly);
        vec_t t;
        t.name = name; t.rst = r; t.lock = lk; t.req = rq; t.val = v; t.clr = c; t.n = n;
        t.exp = {e_rb, e_rdy, e_ack, e_lost, e_fail, e_retry, e_dly};
        tbl.push_back(t);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_vec(input string name, input logic [20:0] act, input logic [20:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got rb/rdy/ack/lost/fail=%b retry=%h dly=%h, expected rb/rdy/ack/lost/fail=%b retry=%h dly=%h",
                     name, act[20:16], act[15:8], act[7:0], exp[20:16], exp[15:8], exp[7:0]);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    initial begin
        int n;
        logic ack_seen;
        logic rb_seen;
        logic rdy_seen;

        hif.DELAY_REQ  = 1'b0;
        hif.DELAY_VAL  = 8'h00;
        hif.CLR_STATUS = 1'b0;

        //   name            rst lk rq val   clr n   rb rdy ack lost fail retry dly
        add("reset_vals",     1, 0, 0, 8'h00, 0, 1,  0, 0, 0, 0, 0, 8'd0, 8'h05);
        add("rst_low_3",      0, 0, 0, 8'h00, 0, 3,  0, 0, 0, 0, 0, 8'd0, 8'h05);
        add("rst_rise_4",     0, 0, 0, 8'h00, 0, 1,  1, 0, 0, 0, 0, 8'd0, 8'h05);
        add("wait_9",         0, 0, 0, 8'h00, 0, 9,  1, 0, 0, 0, 0, 8'd0, 8'h05);
        add("lock_9",         0, 1, 0, 8'h00, 0, 9,  1, 0, 0, 0, 0, 8'd0, 8'h05);
        add("lock_10",        0, 1, 0, 8'h00, 0, 1,  1, 0, 0, 0, 0, 8'd0, 8'h05);
        add("ready_11",       0, 1, 0, 8'h00, 0, 1,  1, 1, 0, 0, 0, 8'd0, 8'h05);
        add("dly_ack",        0, 1, 1, 8'hA3, 0, 1,  1, 0, 1, 0, 0, 8'd0, 8'hA3);
        add("dly_settle7",    0, 1, 0, 8'hA3, 0, 7,  1, 0, 0, 0, 0, 8'd0, 8'hA3);
        add("dly_ready8",     0, 1, 0, 8'hA3, 0, 1,  1, 1, 0, 0, 0, 8'd0, 8'hA3);
        add("loss_1",         0, 0, 0, 8'h00, 0, 1,  1, 1, 0, 0, 0, 8'd0, 8'hA3);
        add("loss_2",         0, 0, 0, 8'h00, 0, 1,  1, 1, 0, 0, 0, 8'd0, 8'hA3);
        add("loss_3",         0, 0, 0, 8'h00, 0, 1,  0, 0, 0, 1, 0, 8'd0, 8'hA3);
        add("loss_rst3",      0, 0, 0, 8'h00, 0, 3,  0, 0, 0, 1, 0, 8'd0, 8'hA3);
        add("loss_rst4",      0, 0, 0, 8'h00, 0, 1,  1, 0, 0, 1, 0, 8'd0, 8'hA3);
        add("clr_status",     0, 0, 0, 8'h00, 1, 1,  1, 0, 0, 0, 0, 8'd0, 8'hA3);
        add("relock",         0, 1, 0, 8'h00, 0, 11, 1, 1, 0, 0, 0, 8'd0, 8'hA3);
        add("drop_again",     0, 0, 0, 8'h00, 0, 2,  1, 1, 0, 0, 0, 8'd0, 8'hA3);
        add("set_beats_clr",  0, 0, 0, 8'h00, 1, 1,  0, 0, 0, 1, 0, 8'd0, 8'hA3);
        add("rst_again",      0, 0, 0, 8'h00, 0, 4,  1, 0, 0, 1, 0, 8'd0, 8'hA3);
        add("relock2",        0, 1, 0, 8'h00, 0, 11, 1, 1, 0, 1, 0, 8'd0, 8'hA3);
        add("coll_pre",       0, 0, 0, 8'h00, 0, 2,  1, 1, 0, 1, 0, 8'd0, 8'hA3);
        add("coll_edge",      0, 0, 1, 8'h3C, 0, 1,  0, 0, 0, 1, 0, 8'd0, 8'hA3);
        add("coll_rst",       0, 1, 1, 8'h3C, 0, 3,  0, 0, 0, 1, 0, 8'd0, 8'hA3);
        add("coll_wait",      0, 1, 1, 8'h3C, 0, 1,  1, 0, 0, 1, 0, 8'd0, 8'hA3);
        add("coll_settle",    0, 1, 1, 8'h3C, 0, 1,  1, 0, 0, 1, 0, 8'd0, 8'hA3);
        add("coll_run",       0, 1, 1, 8'h3C, 0, 8,  1, 1, 0, 1, 0, 8'd0, 8'hA3);
        add("coll_ack",       0, 1, 1, 8'h3C, 0, 1,  1, 0, 1, 1, 0, 8'd0, 8'h3C);
        add("ack_one_cycle",  0, 1, 0, 8'h3C, 0, 1,  1, 0, 0, 1, 0, 8'd0, 8'h3C);
        add("coll_ready",     0, 1, 0, 8'h3C, 0, 7,  1, 1, 0, 1, 0, 8'd0, 8'h3C);
        add("gl_update",      0, 1, 1, 8'h11, 0, 1,  1, 0, 1, 1, 0, 8'd0, 8'h11);
        add("gl_low3",        0, 0, 0, 8'h11, 0, 3,  1, 0, 0, 1, 0, 8'd0, 8'h11);
        add("gl_back",        0, 1, 0, 8'h11, 0, 1,  1, 0, 0, 1, 0, 8'd0, 8'h11);
        add("gl_not_yet",     0, 1, 0, 8'h11, 0, 9,  1, 0, 0, 1, 0, 8'd0, 8'h11);
        add("gl_ready",       0, 1, 0, 8'h11, 0, 1,  1, 1, 0, 1, 0, 8'd0, 8'h11);
        add("mid_update",     0, 1, 1, 8'h7F, 0, 1,  1, 0, 1, 1, 0, 8'd0, 8'h7F);
        add("mid_settle",     0, 1, 0, 8'h7F, 0, 2,  1, 0, 0, 1, 0, 8'd0, 8'h7F);
        add("mid_reset",      1, 1, 0, 8'h7F, 0, 1,  0, 0, 0, 0, 0, 8'd0, 8'h05);

        for (int i = 0; i < tbl.size(); i++) begin
            rst            = tbl[i].rst;
            lock           = tbl[i].lock;
            hif.DELAY_REQ  = tbl[i].req;
            hif.DELAY_VAL  = tbl[i].val;
            hif.CLR_STATUS = tbl[i].clr;
            repeat (tbl[i].n) tick();
            check_vec(tbl[i].name, obs(), tbl[i].exp);
        end

        // Timeout/retry/fail sequence with lock never arriving.
        rst = 1'b1;
        lock = 1'b0;
        hif.DELAY_REQ = 1'b0;
        hif.CLR_STATUS = 1'b0;
        tick();
        rst = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            n = 0;
            while (resetb == 1'b0 && n < 200) begin
                tick();
                n++;
            end
            check_int($sformatf("attempt%0d_low_cycles", k), n, 4);
            n = 0;
            while (resetb == 1'b1 && n < 200) begin
                tick();
                n++;
            end
            check_int($sformatf("attempt%0d_high_cycles", k), n, 32);
            check_int($sformatf("attempt%0d_retry_cnt", k), int'(hif.RETRY_CNT), k);
            check_int($sformatf("attempt%0d_fail", k), int'(hif.FAIL), (k == 3) ? 1 : 0);
        end

        // In FAIL: lock and delay requests have no effect.
        lock = 1'b1;
        hif.DELAY_REQ = 1'b1;
        hif.DELAY_VAL = 8'h55;
        ack_seen = 1'b0;
        rb_seen = 1'b0;
        rdy_seen = 1'b0;
        repeat (20) begin
            tick();
            ack_seen |= hif.DELAY_ACK;
            rb_seen |= resetb;
            rdy_seen |= hif.READY;
        end
        check_int("fail_no_ack", int'(ack_seen), 0);
        check_int("fail_resetb_low", int'(rb_seen), 0);
        check_int("fail_no_ready", int'(rdy_seen), 0);
        check_vec("fail_hold", obs(), {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd3, 8'h05});

        rst = 1'b1;
        hif.DELAY_REQ = 1'b0;
        tick();
        check_vec("fail_exit_reset", obs(), {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'h05});
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
